// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl: buffers HPS ioctl download bytes into 12 MHz ROM write slots
// and holds the game core in reset until the image is loaded and settled.
module rom_download_ctrl #(
  parameter logic [15:0] PROG_END    = 16'h6000,
  parameter logic [15:0] GFX_END     = 16'hA000,
  parameter logic [15:0] SND_END     = 16'hC000,
  parameter logic [16:0] ROM_SIZE    = 17'h0C100,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [3:0]  dn_wr,
  output logic        core_reset,
  output logic        load_done,
  output logic [16:0] byte_count,
  output logic [1:0]  err
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {S_WAIT, S_LOAD, S_DRAIN, S_HOLD, S_RUN} state_t;

  state_t        state, state_n;
  logic          full;
  logic [1:0]    region, region_in;
  logic [CW-1:0] hold_cnt;
  logic          in_range, wr_ok, drain, capture, start, hold_last;

  assign in_range  = ioctl_addr < 25'(ROM_SIZE);
  assign wr_ok     = (state == S_LOAD) && ioctl_download && ioctl_wr;
  assign drain     = full && ce;
  assign capture   = wr_ok && in_range && (!full || drain);
  assign start     = ioctl_download && (state == S_WAIT || state == S_HOLD || state == S_RUN);
  assign hold_last = hold_cnt == CW'(HOLD_CYCLES - 1);
  assign region_in = ioctl_addr < 25'(PROG_END) ? 2'd0 :
                     ioctl_addr < 25'(GFX_END)  ? 2'd1 :
                     ioctl_addr < 25'(SND_END)  ? 2'd2 : 2'd3;
  assign ioctl_wait = full;
  assign dn_wr      = {4{drain}} & (4'b0001 << region);

  always_comb begin
    state_n = state;
    case (state)
      S_WAIT:  state_n = ioctl_download ? S_LOAD : S_WAIT;
      S_LOAD:  state_n = ioctl_download ? S_LOAD : full ? S_DRAIN : S_HOLD;
      S_DRAIN: state_n = (!full || drain) ? S_HOLD : S_DRAIN;
      S_HOLD:  state_n = ioctl_download ? S_LOAD : hold_last ? S_RUN : S_HOLD;
      S_RUN:   state_n = ioctl_download ? S_LOAD : S_RUN;
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_WAIT;
      full       <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      region     <= '0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      byte_count <= '0;
      err        <= '0;
    end else begin
      state      <= state_n;
      core_reset <= state_n != S_RUN;
      full       <= capture || (full && !drain);
      hold_cnt   <= (state == S_HOLD && state_n == S_HOLD) ? hold_cnt + 1'b1 : '0;
      if (capture) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
        region  <= region_in;
      end
      // A new session wipes all status; the buffer is always empty here
      if (start) begin
        load_done  <= 1'b0;
        byte_count <= '0;
        err        <= '0;
      end else begin
        if (drain && byte_count != '1) byte_count <= byte_count + 1'b1;
        if (wr_ok && !in_range) err[0] <= 1'b1;
        if (wr_ok && in_range && full && !drain) err[1] <= 1'b1;
        if (state == S_HOLD && state_n == S_RUN) load_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_download_ctrl.sv
// tb_rom_download_ctrl: directed scoreboard bench for rom_download_ctrl using a
// scaled ROM map so a complete image sweep stays short.
module tb_rom_download_ctrl;
  localparam logic [15:0] P_END = 16'h0600;
  localparam logic [15:0] G_END = 16'h0A00;
  localparam logic [15:0] S_END = 16'h0C00;
  localparam logic [16:0] R_END = 17'h00C10;

  logic        clk_sys = 0, reset_n = 0, ce = 0, ioctl_download = 0, ioctl_wr = 0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, core_reset, load_done;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [3:0]  dn_wr;
  logic [16:0] byte_count;
  logic [1:0]  err;
  logic [1:0]  ph = '0;

  int vectors = 0, miscompares = 0, strobes = 0;
  logic [27:0] sb[$];

  rom_download_ctrl #(
    .PROG_END(P_END), .GFX_END(G_END), .SND_END(S_END), .ROM_SIZE(R_END), .HOLD_CYCLES(1024)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .core_reset(core_reset), .load_done(load_done), .byte_count(byte_count), .err(err)
  );

  initial forever begin
    #5 clk_sys = 1;
    #1 ph = ph + 2'd1;
    ce = ph == 2'd0;
    #4 clk_sys = 0;
  end

  function automatic logic [27:0] ent(input logic [15:0] a, input logic [7:0] d);
    logic [3:0] w;
    w = a < P_END ? 4'b0001 : a < G_END ? 4'b0010 : a < S_END ? 4'b0100 : 4'b1000;
    return {w, a, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (reset_n && dn_wr != 4'b0) begin
      strobes++;
      if (sb.size() == 0) chk("unexpected_strobe", {dn_wr, dn_addr, dn_data}, 32'h0);
      else chk("strobe", {dn_wr, dn_addr, dn_data}, 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic drive(input logic [24:0] a, input logic [7:0] d, input bit push);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1;
    if (push) sb.push_back(ent(a[15:0], d));
    tick();
    ioctl_wr = 0;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit push);
    int n = 0;
    while (ioctl_wait && n < 100) begin
      tick();
      n++;
    end
    drive(a, d, push);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || ioctl_wait) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic align_ce();
    int n = 0;
    while (!(ce && !ioctl_wait) && n < 50) begin
      tick();
      n++;
    end
    chk("align", 32'(n < 50), 32'd1);
  endtask

  initial begin
    int n, s0;
    tick(3);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_dn_wr", 32'(dn_wr), 32'd0);
    chk("rst_dn_addr", 32'(dn_addr), 32'd0);
    chk("rst_dn_data", 32'(dn_data), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_n = 1;
    tick(20);
    chk("idle_core_reset", 32'(core_reset), 32'd1);
    chk("idle_load_done", 32'(load_done), 32'd0);

    ioctl_download = 1;
    tick();
    wr_byte(25'(P_END - 16'd1), 8'hA5, 1);
    wr_byte(25'(P_END), 8'h3C, 1);
    settle("boundary_drain");
    chk("boundary_count", 32'(byte_count), 32'd2);
    chk("boundary_err", 32'(err), 32'd0);

    wr_byte(25'(R_END), 8'h77, 0);
    tick(8);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_count", 32'(byte_count), 32'd2);
    wr_byte(25'h100_0000, 8'h66, 0);
    tick(8);
    chk("oor_hi_count", 32'(byte_count), 32'd2);

    align_ce();
    tick();
    drive(25'h0100, 8'h11, 1);
    chk("ovr_full", 32'({ioctl_wait, ce}), 32'b10);
    drive(25'h0200, 8'h22, 0);
    chk("ovr_err", 32'(err), 32'd3);
    settle("ovr_drain");
    chk("ovr_count", 32'(byte_count), 32'd3);

    ioctl_download = 0;
    tick(3);
    ioctl_download = 1;
    tick();
    chk("restart_count", 32'(byte_count), 32'd0);
    chk("restart_err", 32'(err), 32'd0);
    s0 = strobes;
    for (int a = 0; a < int'(R_END); a++) wr_byte(25'(a), 8'(a) ^ 8'h5A, 1);
    settle("sweep_drain");
    chk("sweep_strobes", 32'(strobes - s0), 32'(R_END));
    chk("sweep_count", 32'(byte_count), 32'(R_END));
    chk("sweep_err", 32'(err), 32'd0);
    wr_byte(25'(R_END) + 25'd5, 8'h00, 0);
    tick(4);
    chk("sweep_oor_err", 32'(err), 32'd1);

    align_ce();
    tick();
    drive(25'(R_END - 17'd1), 8'h5A, 1);
    ioctl_download = 0;
    n = 0;
    while (dn_wr == 4'b0 && n < 10) begin
      tick();
      n++;
    end
    chk("drain_strobe", 32'(dn_wr), 32'b1000);
    chk("drain_core_reset", 32'(core_reset), 32'd1);
    tick(1024);
    chk("hold_end_core_reset", 32'(core_reset), 32'd1);
    chk("hold_end_load_done", 32'(load_done), 32'd0);
    tick();
    chk("run_core_reset", 32'(core_reset), 32'd0);
    chk("run_load_done", 32'(load_done), 32'd1);
    chk("run_count", 32'(byte_count), 32'(R_END) + 32'd1);
    tick(10);
    chk("run_stays", 32'({core_reset, load_done}), 32'b01);
    chk("run_err", 32'(err), 32'd1);

    ioctl_download = 1;
    chk("reload_pre", 32'(core_reset), 32'd0);
    tick();
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_load_done", 32'(load_done), 32'd0);
    chk("reload_count", 32'(byte_count), 32'd0);
    chk("reload_err", 32'(err), 32'd0);

    align_ce();
    tick();
    drive(25'h0123, 8'hEE, 0);
    chk("abort_full", 32'(ioctl_wait), 32'd1);
    reset_n = 0;
    #1;
    chk("abort_wait", 32'(ioctl_wait), 32'd0);
    chk("abort_dn", 32'({dn_wr, dn_addr, dn_data}), 32'd0);
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    tick(2);
    reset_n = 1;
    ioctl_download = 0;
    tick(8);
    chk("abort_core_reset_after", 32'(core_reset), 32'd1);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
